// File: rtl/fetch_execute_sequencer_pkg.sv
// rtl/fetch_execute_sequencer_pkg.sv - sequencer state encodings and shared constants
package fetch_execute_sequencer_pkg;

  // Sequencer FSM states
  typedef enum logic [2:0] {
    SEQ_IDLE  = 3'd0,
    SEQ_FETCH = 3'd1,
    SEQ_EXEC  = 3'd2,
    SEQ_MEM   = 3'd3,
    SEQ_WB    = 3'd4,
    SEQ_HALT  = 3'd5
  } seq_state_t;

  // addi x0, x0, 0 - what the instruction register holds before the first fetch
  localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0013;

  // A control-transfer target must be word aligned
  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_execute_sequencer_seq_pc_register.sv
// rtl/fetch_execute_sequencer_seq_pc_register.sv - PC flop, +4 adder, redirect mux and alignment check
module seq_pc_register
  import fetch_execute_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_commit,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_next,
  output logic        o_misaligned
);

  logic [31:0] r_pc;
  logic [31:0] w_target;

  // Sequential PC wraps naturally through the 32-bit adder
  assign o_pc_next    = r_pc + 32'd4;
  assign o_misaligned = i_redirect_valid && is_misaligned(i_redirect_pc);
  assign w_target     = i_redirect_valid ? i_redirect_pc : o_pc_next;
  assign o_pc         = r_pc;

  // PC advances only on commit; a misaligned redirect leaves it pointing at the faulting instruction
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc <= RESET_PC;
    end else if (i_commit && !o_misaligned) begin
      r_pc <= w_target;
    end
  end

endmodule

// File: rtl/fetch_execute_sequencer.sv
// rtl/fetch_execute_sequencer.sv - fetch/exec/mem/wb sequencer over one shared bus; SEQ_RETIRE_COUNT_EN adds retire/stall counters
module fetch_execute_sequencer
  import fetch_execute_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [2:0]       mem_wlen,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ready,
  output logic [31:0]      instruction,
  output logic [31:0]      pc,
  output logic [31:0]      pc_next,
  input  logic [31:0]      dp_addr,
  input  logic [31:0]      dp_wdata,
  input  logic [2:0]       dp_wlen,
  input  logic             dp_mem_write,
  input  logic             dp_mem_read,
  output logic [31:0]      load_data,
`ifdef SEQ_RETIRE_COUNT_EN
  output logic [CNT_W-1:0] retired,
  output logic [CNT_W-1:0] stall_cycles,
`endif
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic             commit,
  output logic             halted
);

  seq_state_t  r_state;
  seq_state_t  w_next_state;
  logic [31:0] r_instruction;
  logic [31:0] r_load_data;
  logic        w_misaligned;
  logic        w_mem_op;

  // A store takes priority when the datapath asserts both read and write
  assign w_mem_op = dp_mem_read || dp_mem_write;

  seq_pc_register #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk              (clk),
    .reset_n          (reset_n),
    .i_commit         (commit),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .o_pc             (pc),
    .o_pc_next        (pc_next),
    .o_misaligned     (w_misaligned)
  );

  // State register; async reset drops the bus request combinationally via the state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= SEQ_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state, bus muxing and commit strobe; bus outputs depend only on state and held inputs
  always_comb begin
    w_next_state = r_state;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = pc;
    mem_wdata    = 32'h0;
    mem_wlen     = 3'b000;
    commit       = 1'b0;
    case (r_state)
      SEQ_IDLE: begin
        w_next_state = SEQ_FETCH;
      end
      SEQ_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc;
        if (mem_ready) w_next_state = SEQ_EXEC;
      end
      SEQ_EXEC: begin
        if (w_mem_op) begin
          w_next_state = SEQ_MEM;
        end else begin
          commit       = 1'b1;
          w_next_state = w_misaligned ? SEQ_HALT : SEQ_FETCH;
        end
      end
      SEQ_MEM: begin
        mem_req   = 1'b1;
        mem_addr  = dp_addr;
        mem_we    = dp_mem_write;
        mem_wdata = dp_wdata;
        mem_wlen  = dp_wlen;
        if (mem_ready) w_next_state = SEQ_WB;
      end
      SEQ_WB: begin
        commit       = 1'b1;
        w_next_state = w_misaligned ? SEQ_HALT : SEQ_FETCH;
      end
      SEQ_HALT: begin
        w_next_state = SEQ_HALT;
      end
      default: begin
        w_next_state = SEQ_IDLE;
      end
    endcase
  end

  // Capture the fetched instruction and load data on the completing bus beat
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_instruction <= NOP_INSTRUCTION;
      r_load_data   <= 32'h0;
    end else begin
      if (r_state == SEQ_FETCH && mem_ready) begin
        r_instruction <= mem_rdata;
      end
      if (r_state == SEQ_MEM && mem_ready && dp_mem_read && !dp_mem_write) begin
        r_load_data <= mem_rdata;
      end
    end
  end

  assign instruction = r_instruction;
  assign load_data   = r_load_data;
  assign halted      = (r_state == SEQ_HALT);

`ifdef SEQ_RETIRE_COUNT_EN
  logic [CNT_W-1:0] r_retired;
  logic [CNT_W-1:0] r_stall_cycles;

  // Retired-instruction and bus-stall counters, both free-running with wrap
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_retired      <= '0;
      r_stall_cycles <= '0;
    end else begin
      if (commit) r_retired <= r_retired + 1'b1;
      if (mem_req && !mem_ready) r_stall_cycles <= r_stall_cycles + 1'b1;
    end
  end

  assign retired      = r_retired;
  assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_fetch_execute_sequencer.sv
// tb/tb_fetch_execute_sequencer.sv - directed self-checking bench for fetch_execute_sequencer
module tb_fetch_execute_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_wlen, dp_wlen;
  logic [31:0] instruction, pc, pc_next, dp_addr, dp_wdata, load_data, redirect_pc;
  logic        dp_mem_write, dp_mem_read, redirect_valid, commit, halted;
`ifdef SEQ_RETIRE_COUNT_EN
  logic [31:0] retired, stall_cycles;
`endif

  int checks = 0;
  int errors = 0;
  int n_commit = 0;
  int c0;

  always #5 clk = ~clk;

  always @(posedge clk) if (commit) n_commit <= n_commit + 1;

  fetch_execute_sequencer #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wlen(mem_wlen), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .instruction(instruction), .pc(pc), .pc_next(pc_next),
    .dp_addr(dp_addr), .dp_wdata(dp_wdata), .dp_wlen(dp_wlen),
    .dp_mem_write(dp_mem_write), .dp_mem_read(dp_mem_read), .load_data(load_data),
`ifdef SEQ_RETIRE_COUNT_EN
    .retired(retired), .stall_cycles(stall_cycles),
`endif
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .commit(commit), .halted(halted)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h0010_0093;
    dp_addr = '0; dp_wdata = '0; dp_wlen = '0; dp_mem_write = 1'b0; dp_mem_read = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    tick(); tick();
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_commit", {31'd0, commit}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instruction, 32'h0000_0013);
    chk("rst_load_data", load_data, 32'h0);

    // 1: ALU instruction with zero-wait memory
    reset_n = 1'b1;
    chk("idle_mem_req", {31'd0, mem_req}, 32'd0);
    tick();
    chk("t1_fetch_req", {31'd0, mem_req}, 32'd1);
    chk("t1_fetch_addr", mem_addr, 32'h0);
    chk("t1_fetch_we", {31'd0, mem_we}, 32'd0);
    chk("t1_fetch_commit", {31'd0, commit}, 32'd0);
    tick();
    chk("t1_exec_commit", {31'd0, commit}, 32'd1);
    chk("t1_instr", instruction, 32'h0010_0093);
    chk("t1_pc_next", pc_next, 32'h4);
    tick();
    chk("t1_pc", pc, 32'h4);
    chk("t1_next_fetch_addr", mem_addr, 32'h4);
    chk("t1_fetch2_commit", {31'd0, commit}, 32'd0);

    // 2: load with three wait cycles, seven cycles total
    c0 = n_commit;
    mem_rdata = 32'h1000_2083; dp_mem_read = 1'b1; dp_addr = 32'h100; #1;
    tick();
    mem_ready = 1'b0; #1;
    chk("t2_exec_commit", {31'd0, commit}, 32'd0);
    chk("t2_exec_req", {31'd0, mem_req}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_wait_req", {31'd0, mem_req}, 32'd1);
      chk("t2_wait_addr", mem_addr, 32'h100);
      chk("t2_wait_we", {31'd0, mem_we}, 32'd0);
      chk("t2_wait_commit", {31'd0, commit}, 32'd0);
    end
    tick();
    mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF; #1;
    chk("t2_ready_addr", mem_addr, 32'h100);
    tick();
    chk("t2_wb_commit", {31'd0, commit}, 32'd1);
    chk("t2_load_data", load_data, 32'hDEAD_BEEF);
    chk("t2_wb_req", {31'd0, mem_req}, 32'd0);
    tick();
    dp_mem_read = 1'b0;
    // 3: store (read also asserted, store wins)
    mem_rdata = 32'h0020_A023; dp_mem_write = 1'b1; dp_mem_read = 1'b1;
    dp_addr = 32'h200; dp_wdata = 32'h55; dp_wlen = 3'b010; #1;
    chk("t2_commit_once", n_commit - c0, 32'd1);
    chk("t2_pc", pc, 32'h8);
    tick();
    mem_ready = 1'b0; #1;
    chk("t3_exec_commit", {31'd0, commit}, 32'd0);
    tick();
    chk("t3_we", {31'd0, mem_we}, 32'd1);
    chk("t3_wlen", {29'd0, mem_wlen}, 32'd2);
    chk("t3_wdata", mem_wdata, 32'h55);
    chk("t3_addr", mem_addr, 32'h200);
    tick();
    mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D; #1;
    chk("t3_we_hold", {31'd0, mem_we}, 32'd1);
    chk("t3_wdata_hold", mem_wdata, 32'h55);
    tick();
    chk("t3_wb_commit", {31'd0, commit}, 32'd1);
    chk("t3_load_kept", load_data, 32'hDEAD_BEEF);
    chk("t3_wb_req", {31'd0, mem_req}, 32'd0);
    tick();
    dp_mem_write = 1'b0; dp_mem_read = 1'b0; mem_rdata = 32'h0400_006F; #1;
    chk("t3_pc", pc, 32'hC);

    // 4: taken branch, wrap, misaligned redirect
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h40; #1;
    chk("t4_br_commit", {31'd0, commit}, 32'd1);
    tick();
    redirect_valid = 1'b0; #1;
    chk("t4_br_fetch_addr", mem_addr, 32'h40);
    chk("t4_br_pc", pc, 32'h40);
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; #1;
    tick();
    redirect_valid = 1'b0; #1;
    chk("t4_wrap_fetch_addr", mem_addr, 32'hFFFF_FFFC);
    tick();
    chk("t4_wrap_pc_next", pc_next, 32'h0);
    tick();
    chk("t4_wrap_pc", pc, 32'h0);
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h42; #1;
    chk("t4_mis_commit", {31'd0, commit}, 32'd1);
    tick();
    redirect_valid = 1'b0; #1;
    chk("t4_halted", {31'd0, halted}, 32'd1);
    chk("t4_halt_commit", {31'd0, commit}, 32'd0);
    chk("t4_halt_pc", pc, 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_halt_req", {31'd0, mem_req}, 32'd0);
      chk("t4_halt_sticky", {31'd0, halted}, 32'd1);
    end

    // 5: reset during a stalled fetch
    reset_n = 1'b0; #1;
    chk("t5_halt_cleared", {31'd0, halted}, 32'd0);
    tick();
    reset_n = 1'b1; mem_rdata = 32'h0010_0093;
    tick(); tick(); tick();
    mem_ready = 1'b0; mem_rdata = 32'h1234_5678; #1;
    chk("t5_pc_before", pc, 32'h4);
    tick();
    chk("t5_wait_req", {31'd0, mem_req}, 32'd1);
    #2; reset_n = 1'b0; #1;
    chk("t5_req_dropped", {31'd0, mem_req}, 32'd0);
    chk("t5_pc_reset", pc, 32'h0);
    chk("t5_instr_nop", instruction, 32'h0000_0013);
    tick();
    reset_n = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h0010_0093;
    tick();
    chk("t5_refetch_req", {31'd0, mem_req}, 32'd1);
    chk("t5_refetch_addr", mem_addr, 32'h0);
    chk("t5_instr_after", instruction, 32'h0000_0013);

`ifdef SEQ_RETIRE_COUNT_EN
    // 6: counters over ten single-wait ALU instructions
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      mem_ready = 1'b0;
      tick();
      mem_ready = 1'b1;
      tick(); tick();
    end
    chk("t6_retired", retired, 32'd10);
    chk("t6_stalls", stall_cycles, 32'd10);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
